codec_i2c_master: RTL and testbench

Write-only I2C master that carries WM8731 control words from the codec slave interface onto the codec's 2-wire control bus. When `wr_i2c` is asserted, it accepts a 24-bit packet (device address byte, then two register/data bytes) and serialises it as START, 3×(8 bits + ACK slot), STOP. It reports bus availability on `i2c_idle`, which gates further writes upstream (wait-request generation). It flags a missing acknowledge on `ack_err`.

---
 rtl/codec_i2c_master.sv | 178 +++++++++++++++++
 tb/tb_codec_i2c_master.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_i2c_master.sv
// codec_i2c_master
//   Write-only I2C master for WM8731 control words. A 24-bit packet
//   (address byte + two data bytes) is sent as START, 3 x (8 bits + ACK slot),
//   STOP. A missing acknowledge aborts the transfer to STOP and raises ack_err.
//
// Parameters
//   CLK_DIV      Clk cycles per SCL quarter-period (4..65535)
//
// Ports
//   Clk          system clock
//   Rst_n        asynchronous reset, active-high
//   i2c_packet   [23:16] address byte, [15:8] / [7:0] data bytes; sampled on accept
//   wr_i2c       start request, honoured only while i2c_idle is high
//   i2c_idle     high = ready to accept a packet
//   i2c_done     one-cycle pulse at the end of a transfer (normal or aborted)
//   ack_err      sticky NACK flag for the last transfer, cleared on accept
//   i2c_sclk     SCL, push-pull
//   i2c_sdat_oe  high = pull SDA low, low = release
//   i2c_sdat_i   SDA line level (asynchronous)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | bus released, SCL high, counters held at zero
// S_START | q0-q1 SDA released, q2-q3 SDA low, SCL high throughout
// S_BIT   | q0-q1 SCL low with data bit driven, q2-q3 SCL high
// S_ACK   | SDA released, SCL low q0-q1 / high q2-q3, sample at q3 entry
// S_STOP  | q0 SCL low SDA low, q1 SCL high SDA low, q2-q3 SDA released

module codec_i2c_master #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [23:0] i2c_packet,
  input  logic        wr_i2c,
  output logic        i2c_idle,
  output logic        i2c_done,
  output logic        ack_err,
  output logic        i2c_sclk,
  output logic        i2c_sdat_oe,
  input  logic        i2c_sdat_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_t      r_state;
  logic [15:0] r_div_cnt;
  logic [1:0]  r_q;
  logic [2:0]  r_bit_cnt;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_shift;
  logic        r_sda_meta;
  logic        r_sda_sync;
  logic        r_idle;
  logic        r_done;
  logic        r_ack_err;
  logic        r_scl;
  logic        r_sda_oe;
  logic        w_tick;

  assign w_tick      = (r_div_cnt == DIV_LAST);
  assign i2c_idle    = r_idle;
  assign i2c_done    = r_done;
  assign ack_err     = r_ack_err;
  assign i2c_sclk    = r_scl;
  assign i2c_sdat_oe = r_sda_oe;

  // Idle bus level is high, so the synchroniser resets to 1.
  always_ff @(posedge Clk or posedge Rst_n) begin
    if (Rst_n) begin
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
    end else begin
      r_sda_meta <= i2c_sdat_i;
      r_sda_sync <= r_sda_meta;
    end
  end

  // Outputs are assigned on the tick that enters each quarter, so every bus
  // transition is registered and lands exactly on a tick boundary.
  always_ff @(posedge Clk or posedge Rst_n) begin
    if (Rst_n) begin
      r_state    <= S_IDLE;
      r_div_cnt  <= '0;
      r_q        <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_idle     <= 1'b1;
      r_done     <= 1'b0;
      r_ack_err  <= 1'b0;
      r_scl      <= 1'b1;
      r_sda_oe   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_div_cnt  <= '0;
        r_q        <= '0;
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
        if (wr_i2c) begin
          r_shift   <= i2c_packet;
          r_ack_err <= 1'b0;
          r_idle    <= 1'b0;
          r_bit_cnt <= 3'd7;
          r_state   <= S_START;
        end
      end else if (!w_tick) begin
        r_div_cnt <= r_div_cnt + 16'd1;
      end else begin
        r_div_cnt <= '0;
        r_q       <= r_q + 2'd1;   // wraps to q0 on every state change
        case (r_state)
          S_START: begin
            if (r_q == 2'd1) r_sda_oe <= 1'b1;
            if (r_q == 2'd3) begin
              r_state  <= S_BIT;
              r_scl    <= 1'b0;
              r_sda_oe <= ~r_shift[23];
            end
          end
          S_BIT: begin
            if (r_q == 2'd1) r_scl <= 1'b1;
            if (r_q == 2'd3) begin
              r_shift <= {r_shift[22:0], 1'b0};
              r_scl   <= 1'b0;
              if (r_bit_cnt == 3'd0) begin
                r_state  <= S_ACK;
                r_sda_oe <= 1'b0;
              end else begin
                r_bit_cnt <= r_bit_cnt - 3'd1;
                // next bit is the one about to become MSB after this shift
                r_sda_oe  <= ~r_shift[22];
              end
            end
          end
          S_ACK: begin
            if (r_q == 2'd1) r_scl <= 1'b1;
            if (r_q == 2'd2 && r_sda_sync) r_ack_err <= 1'b1;
            if (r_q == 2'd3) begin
              r_scl <= 1'b0;
              // ack_err was cleared on accept and any NACK aborts at once,
              // so here it reflects only this byte's ACK slot.
              if (r_ack_err || r_byte_cnt == 2'd2) begin
                r_state  <= S_STOP;
                r_sda_oe <= 1'b1;
              end else begin
                r_state    <= S_BIT;
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_bit_cnt  <= 3'd7;
                r_sda_oe   <= ~r_shift[23];
              end
            end
          end
          S_STOP: begin
            if (r_q == 2'd0) r_scl    <= 1'b1;
            if (r_q == 2'd1) r_sda_oe <= 1'b0;
            if (r_q == 2'd3) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_idle  <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_codec_i2c_master.sv
// Testbench for codec_i2c_master at CLK_DIV=4. A bus monitor decodes START,
// data/ACK bits and STOP from the pins, acts as an ACKing slave (optionally
// NACKing one byte), measures i2c_idle low time and flags illegal SDA
// changes while SCL is high. Transfers are compared against a reference model.

module tb_codec_i2c_master;
  localparam int DIV = 4;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        wr_i2c = 1'b0;
  logic [23:0] i2c_packet = '0;
  logic        i2c_idle, i2c_done, ack_err, i2c_sclk, i2c_sdat_oe, i2c_sdat_i;
  logic        slave_pull = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  assign i2c_sdat_i = ~(i2c_sdat_oe | slave_pull);

  codec_i2c_master #(.CLK_DIV(DIV)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .i2c_packet  (i2c_packet),
    .wr_i2c      (wr_i2c),
    .i2c_idle    (i2c_idle),
    .i2c_done    (i2c_done),
    .ack_err     (ack_err),
    .i2c_sclk    (i2c_sclk),
    .i2c_sdat_oe (i2c_sdat_oe),
    .i2c_sdat_i  (i2c_sdat_i)
  );

  typedef struct {
    int          nbits;
    logic [35:0] bits;
  } xfer_t;

  xfer_t       xq[$];
  int          idle_q[$];
  int          done_cnt = 0;
  int          illegal = 0;
  int          lowcnt = 0;
  int          bitpos = 0;
  int          mn = 0;
  int          nack_byte = 3;
  logic        in_xfer = 1'b0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        mon_sda;
  logic [35:0] mbits = '0;
  xfer_t       mon_x;

  // Bus monitor and slave model
  always @(negedge Clk) begin
    mon_sda = i2c_sdat_i;
    if (Rst_n) begin
      in_xfer    = 1'b0;
      slave_pull = 1'b0;
      lowcnt     = 0;
      bitpos     = 0;
      mn         = 0;
      mbits      = '0;
    end else begin
      if (i2c_done) done_cnt++;
      if (!i2c_idle) lowcnt++;
      else if (lowcnt > 0) begin
        idle_q.push_back(lowcnt);
        lowcnt = 0;
      end
      if (prev_scl && i2c_sclk && mon_sda != prev_sda) begin
        if (!mon_sda) begin
          if (in_xfer) illegal++;
          in_xfer = 1'b1;
          bitpos  = 0;
          mn      = 0;
          mbits   = '0;
        end else begin
          if (!in_xfer) illegal++;
          else begin
            // the SCL pulse that sets up STOP is not a data bit
            mon_x.nbits = mn - 1;
            mon_x.bits  = mbits >> 1;
            xq.push_back(mon_x);
          end
          in_xfer = 1'b0;
        end
      end else if (in_xfer && !prev_scl && i2c_sclk) begin
        mbits = {mbits[34:0], mon_sda};
        mn++;
        bitpos++;
      end else if (in_xfer && prev_scl && !i2c_sclk) begin
        slave_pull = ((bitpos % 9) == 8) && ((bitpos / 9) != nack_byte);
      end
    end
    prev_scl = i2c_sclk;
    prev_sda = mon_sda;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  // Reference: n bytes go out (the NACKed byte is the last), each as 8 bits
  // MSB first plus an ACK bit; idle is low for START + n*9 slots + STOP.
  function automatic void model(input logic [23:0] p, input int nack,
                                output logic [35:0] bits, output int nbits,
                                output int idle_len, output logic aerr);
    int nb;
    nb    = (nack < 3) ? nack + 1 : 3;
    bits  = '0;
    nbits = 0;
    for (int b = 0; b < nb; b++) begin
      logic [7:0] by;
      by = p[23 - 8*b -: 8];
      for (int i = 7; i >= 0; i--) begin
        bits = {bits[34:0], by[i]};
        nbits++;
      end
      bits = {bits[34:0], (b == nack)};
      nbits++;
    end
    idle_len = (8 + 36 * nb) * DIV;
    aerr     = (nack < 3);
  endfunction

  int xq_base, iq_base, done_base, il_base;

  task automatic start_xfer(input logic [23:0] p, input int nack);
    nack_byte  = nack;
    xq_base    = xq.size();
    iq_base    = idle_q.size();
    done_base  = done_cnt;
    il_base    = illegal;
    i2c_packet = p;
    wr_i2c     = 1'b1;
    tick();
    wr_i2c     = 1'b0;
    i2c_packet = 24'($urandom);
    check("accept_idle_low", i2c_idle, 1'b0);
    check("accept_clears_ack_err", ack_err, 1'b0);
  endtask

  task automatic finish_xfer(input string tag, input logic [23:0] p, input int nack,
                             input int exp_idle, input logic exp_err);
    logic [35:0] eb;
    int          en, el;
    logic        ea;
    bit          got;
    model(p, nack, eb, en, el, ea);
    got = 1'b0;
    for (int c = 0; c < 200 * DIV && !got; c++) begin
      tick();
      if (i2c_done) got = 1'b1;
    end
    check({tag, "_done_seen"}, got, 1'b1);
    check({tag, "_idle_at_done"}, i2c_idle, 1'b1);
    check({tag, "_ack_err"}, ack_err, exp_err);
    check({tag, "_model_ack_err"}, ack_err, ea);
    check({tag, "_idle_count"}, idle_q.size(), iq_base + 1);
    if (idle_q.size() > iq_base) begin
      check({tag, "_idle_len"}, idle_q[iq_base], exp_idle);
      check({tag, "_model_idle_len"}, idle_q[iq_base], el);
    end
    check({tag, "_xfer_count"}, xq.size(), xq_base + 1);
    if (xq.size() > xq_base) begin
      check({tag, "_nbits"}, xq[xq_base].nbits, en);
      check({tag, "_bits"}, xq[xq_base].bits, eb);
    end
    check({tag, "_done_pulses"}, done_cnt - done_base, 1);
    check({tag, "_legal_bus"}, illegal, il_base);
  endtask

  typedef struct {
    logic [23:0] pkt;
    int          nack;
    int          exp_idle;
    logic        exp_err;
  } vec_t;

  vec_t vt[6];

  initial begin
    int r;
    logic [23:0] rp;

    vt[0] = '{24'h341E00, 3, 464, 1'b0};
    vt[1] = '{24'h341E00, 0, 176, 1'b1};
    vt[2] = '{24'h340E53, 1, 320, 1'b1};
    vt[3] = '{24'hABCDEF, 2, 464, 1'b1};
    vt[4] = '{24'hFFFFFF, 3, 464, 1'b0};
    vt[5] = '{24'h000000, 3, 464, 1'b0};

    #1 Rst_n = 1'b1;
    #11;
    check("rst_idle", i2c_idle, 1'b1);
    check("rst_done", i2c_done, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_sclk", i2c_sclk, 1'b1);
    check("rst_sdat_oe", i2c_sdat_oe, 1'b0);
    @(negedge Clk);
    #1 Rst_n = 1'b0;
    repeat (3) tick();

    // Table-driven transfers
    for (int i = 0; i < 6; i++) begin
      start_xfer(vt[i].pkt, vt[i].nack);
      finish_xfer($sformatf("vec%0d", i), vt[i].pkt, vt[i].nack, vt[i].exp_idle, vt[i].exp_err);
      repeat (5) tick();
    end

    // Address NACK: ack_err sticky until the next accept
    start_xfer(24'h341E00, 0);
    finish_xfer("nack", 24'h341E00, 0, 176, 1'b1);
    repeat (20) tick();
    check("nack_sticky", ack_err, 1'b1);
    start_xfer(24'h341E00, 3);
    finish_xfer("after_nack", 24'h341E00, 3, 464, 1'b0);
    repeat (5) tick();

    // Busy write ignored
    start_xfer(24'h341E00, 3);
    repeat (98) tick();
    i2c_packet = 24'h340C00;
    wr_i2c     = 1'b1;
    tick();
    wr_i2c     = 1'b0;
    finish_xfer("busy", 24'h341E00, 3, 464, 1'b0);
    repeat (30) tick();
    check("busy_no_second_idle", i2c_idle, 1'b1);
    check("busy_no_second_xfer", xq.size(), xq_base + 1);
    check("busy_no_second_done", done_cnt - done_base, 1);

    // Back-to-back: request issued in the i2c_done cycle
    start_xfer(24'h341E00, 3);
    finish_xfer("b2b_first", 24'h341E00, 3, 464, 1'b0);
    start_xfer(24'h340E53, 3);
    check("b2b_sclk_high", i2c_sclk, 1'b1);
    finish_xfer("b2b_second", 24'h340E53, 3, 464, 1'b0);
    repeat (5) tick();

    // Reset during byte 2
    start_xfer(24'h341E00, 3);
    repeat (200) tick();
    @(posedge Clk);
    #2 Rst_n = 1'b1;
    #1;
    check("midrst_sclk", i2c_sclk, 1'b1);
    check("midrst_sdat_oe", i2c_sdat_oe, 1'b0);
    check("midrst_idle", i2c_idle, 1'b1);
    check("midrst_done", i2c_done, 1'b0);
    repeat (3) @(negedge Clk);
    #1 Rst_n = 1'b0;
    repeat (3) tick();
    check("midrst_no_xfer", xq.size(), xq_base);
    start_xfer(24'h341E00, 3);
    finish_xfer("post_rst", 24'h341E00, 3, 464, 1'b0);
    repeat (5) tick();

    // Randomised packets and NACK positions against the model
    for (int k = 0; k < 8; k++) begin
      logic [35:0] eb;
      int en, el;
      logic ea;
      rp = 24'($urandom);
      r  = $urandom_range(0, 5);
      if (r > 3) r = 3;
      model(rp, r, eb, en, el, ea);
      start_xfer(rp, r);
      finish_xfer($sformatf("rnd%0d", k), rp, r, el, ea);
      repeat ($urandom_range(1, 6)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
